// File: rtl/neo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : neo_pkg
//  Purpose  : Shared slot numbering, arbiter state encoding and small helpers
//             for the palette RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package neo_pkg;

  // Slot numbering inside one 4-cycle palette RAM pass.
  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_VID0 = 2'd0;
  localparam slot_t SLOT_VID1 = 2'd1;
  localparam slot_t SLOT_CPU0 = 2'd2;
  localparam slot_t SLOT_CPU1 = 2'd3;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS1 = 2'd1,
    ST_ACCESS2 = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_t;

  // True while the CPU owns the RAM bus.
  function automatic logic is_access(input arb_state_t st);
    return (st == ST_ACCESS1) || (st == ST_ACCESS2);
  endfunction

  // True for the two slots that belong to video in an uncontended pass.
  function automatic logic is_video_slot(input slot_t s);
    return (s == SLOT_VID0) || (s == SLOT_VID1);
  endfunction

  // True for the two slots that form the regular CPU window.
  function automatic logic is_cpu_slot(input slot_t s);
    return (s == SLOT_CPU0) || (s == SLOT_CPU1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/neo_palslot.sv
`default_nettype none
// ============================================================================
//  Module   : neo_palslot
//  Purpose  : 2-bit palette slot counter. Free-runs 0..3 and is forced back to
//             slot 0 on the edge following a PIXSYNC pulse so the video fetch
//             stays aligned with the pixel pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module neo_palslot
  import neo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  pixsync,
  output slot_t slot,
  output slot_t slot_next
);

  // Value the counter takes on the coming edge; the arbiter looks ahead with it.
  assign slot_next = pixsync ? SLOT_VID0 : slot + 2'd1;

  // Slot register, wraps naturally from 3 to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT_VID0;
    end else begin
      slot <= slot_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/neo_palarb.sv
`default_nettype none
// ============================================================================
//  Module   : neo_palarb
//  Purpose  : Palette RAM arbiter. Shares one asynchronous palette SRAM
//             between the video fetch (slots 0-1) and 68k CPU accesses
//             (slots 2-3, or slots 0-1 during blanking). All RAM-side
//             outputs are registered so they are glitch free and take their
//             idle values directly from the asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module neo_palarb
  import neo_pkg::*;
(
  input  logic        CLK_24M,
  input  logic        nRESET,
  // video side
  input  logic        PIXSYNC,
  input  logic        nBNKB,
  input  logic [11:0] PA_VID,
  input  logic        PALBNK,
  // CPU side
  input  logic        nPAL,
  input  logic        M68K_RW,
  input  logic [11:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  input  logic        nLDS,
  input  logic        nUDS,
  output logic [15:0] CPU_RDATA,
  output logic        nPALDTACK,
  // palette RAM side
  output logic [12:0] PAL_ADDR,
  output logic [15:0] PAL_WDATA,
  input  logic [15:0] PAL_RDATA,
  output logic        nPALOE,
  output logic        nPALWEL,
  output logic        nPALWEU,
  output logic [15:0] VID_COLOR
);

  slot_t      slot;
  slot_t      slot_next;
  arb_state_t state;
  arb_state_t state_next;

  logic       grant;        // IDLE -> ACCESS1 on the coming edge
  logic       slot_ok;      // the coming slot may host ACCESS1
  logic       cap_rw;       // captured M68K_RW (1 = read)
  logic       cap_lds_n;    // captured lower data strobe
  logic       cap_uds_n;    // captured upper data strobe
  logic       access_prev;  // CPU owned the bus during the previous cycle

  neo_palslot u_slot (
    .clk       (CLK_24M),
    .rst_n     (nRESET),
    .pixsync   (PIXSYNC),
    .slot      (slot),
    .slot_next (slot_next)
  );

  // Acknowledge is a pure decode of the ACK state, so it drops back the
  // moment the FSM leaves ACK and is inactive straight out of reset.
  assign nPALDTACK = (state != ST_ACK);

  // Next-state logic: the access pair always runs to completion; the
  // acknowledge is withheld if the CPU has already given up.
  always_comb begin
    state_next = state;
    slot_ok    = (slot_next == SLOT_CPU0) || (!nBNKB && (slot_next == SLOT_VID0));
    case (state)
      ST_IDLE: begin
        if (!nPAL && slot_ok) begin
          state_next = ST_ACCESS1;
        end
      end
      ST_ACCESS1: begin
        state_next = ST_ACCESS2;
      end
      ST_ACCESS2: begin
        state_next = nPAL ? ST_IDLE : ST_ACK;
      end
      ST_ACK: begin
        if (nPAL) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    grant = (state == ST_IDLE) && (state_next == ST_ACCESS1);
  end

  // FSM state register.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // RAM-side outputs, prepared one edge ahead from the next state and slot.
  // CPU request fields are frozen at the grant so a changing bus cannot
  // disturb an access already in flight.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      PAL_ADDR  <= '0;
      PAL_WDATA <= '0;
      nPALOE    <= 1'b1;
      nPALWEL   <= 1'b1;
      nPALWEU   <= 1'b1;
      cap_rw    <= 1'b1;
      cap_lds_n <= 1'b1;
      cap_uds_n <= 1'b1;
    end else begin
      nPALWEL <= 1'b1;
      nPALWEU <= 1'b1;
      if (grant) begin
        cap_rw    <= M68K_RW;
        cap_lds_n <= nLDS;
        cap_uds_n <= nUDS;
        PAL_ADDR  <= {PALBNK, CPU_ADDR};
        PAL_WDATA <= CPU_WDATA;
        nPALOE    <= ~M68K_RW;
      end else if (state_next == ST_ACCESS2) begin
        // Second access cycle: address and data held, byte strobes fire.
        nPALOE  <= ~cap_rw;
        nPALWEL <= cap_rw | cap_lds_n;
        nPALWEU <= cap_rw | cap_uds_n;
      end else if (is_video_slot(slot_next)) begin
        PAL_ADDR <= {PALBNK, PA_VID};
        nPALOE   <= 1'b0;
      end else begin
        // Idle CPU window: keep the video address, release the output enable.
        nPALOE <= 1'b1;
      end
    end
  end

  // Read data capture at the end of ACCESS2.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      CPU_RDATA <= '0;
    end else if ((state == ST_ACCESS2) && cap_rw) begin
      CPU_RDATA <= PAL_RDATA;
    end
  end

  // Video colour latch at the end of slot 1. A pass where the CPU held the
  // bus in either video slot would return CPU data, so that fetch is skipped
  // and the previous colour is kept.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      VID_COLOR   <= '0;
      access_prev <= 1'b0;
    end else begin
      access_prev <= is_access(state);
      if ((slot == SLOT_VID1) && !is_access(state) && !access_prev) begin
        VID_COLOR <= PAL_RDATA;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/neo_palarb.md
NEO_PALARB -- requirements
Module: neo_palarb

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports: CLK_24M in 1, 24 MHz master clock; nRESET in 1, async active-low reset.
REQ-002 SHALL have ports: PIXSYNC in 1, pulse that resyncs the slot counter; nBNKB in 1, 0 = blanking; PA_VID in 12, video palette index; PALBNK in 1, palette bank.
REQ-003 SHALL have CPU ports: nPAL in 1, palette select (active low); M68K_RW in 1, 1 = read; CPU_ADDR in 12, A12~A1; CPU_WDATA in 16; nLDS and nUDS in 1 each; CPU_RDATA out 16; nPALDTACK out 1.
REQ-004 SHALL have RAM ports: PAL_ADDR out 13; PAL_WDATA out 16; PAL_RDATA in 16; nPALOE out 1; nPALWEL and nPALWEU out 1 each; VID_COLOR out 16, latched pixel colour.

Function
REQ-005 SHALL run a 2-bit slot counter SLOT that increments each CLK_24M, wrapping 3->0, and loads 0 on the edge after PIXSYNC=1 regardless of its current value.
REQ-006 SHALL give slots 0-1 to video: PAL_ADDR={PALBNK,PA_VID}, nPALOE=0, VID_COLOR<=PAL_RDATA at the end of slot 1.
REQ-007 SHALL give slots 2-3 to the CPU window; when no CPU access is active, PAL_ADDR SHALL hold its video value and nPALOE=1.
REQ-008 SHALL implement FSM states IDLE, ACCESS1, ACCESS2, ACK.
REQ-009 IDLE->ACCESS1 SHALL occur when nPAL=0 and the next slot is 2; while nBNKB=0, the next slot being 0 also qualifies.
REQ-010 ACCESS1 and ACCESS2 SHALL each last one cycle; PAL_ADDR={PALBNK,CPU_ADDR}.
REQ-011 In both access cycles of a read, nPALOE SHALL be 0 and CPU_RDATA SHALL latch PAL_RDATA at the end of ACCESS2.
REQ-012 In ACCESS1 and ACCESS2 of a write, PAL_WDATA=CPU_WDATA and nPALOE=1.
REQ-013 In ACCESS2 only, nPALWEL SHALL be 0 iff nLDS=0, and nPALWEU SHALL be 0 iff nUDS=0.
REQ-014 ACCESS2->ACK SHALL occur if nPAL=0; otherwise the FSM SHALL go to IDLE (abort) with no acknowledge.
REQ-015 In ACK, nPALDTACK SHALL be 0; ACK->IDLE when nPAL=1, and nPALDTACK SHALL return to 1 that same cycle.
REQ-016 Worst-case active-display latency from nPAL falling to nPALDTACK=0 SHALL be 6 cycles; minimum SHALL be 3 cycles.
REQ-017 A video fetch colliding with ACCESS1/ACCESS2 (blanking start at slot 0, or PIXSYNC mid-access) SHALL be skipped, VID_COLOR holding; the CPU access always completes.
REQ-018 CPU_ADDR, CPU_WDATA, M68K_RW, nLDS and nUDS SHALL be captured on IDLE->ACCESS1 and held through ACCESS2.
REQ-019 A read or write strobe SHALL never be asserted in IDLE or ACK.

Reset
REQ-020 On nRESET=0, asynchronously: SLOT=0, FSM=IDLE, nPALDTACK=1, nPALWEL=nPALWEU=1, nPALOE=1, VID_COLOR=0, CPU_RDATA=0, PAL_WDATA=0, PAL_ADDR=0.
REQ-021 Reset asserted mid-access SHALL abort the access immediately; no write strobe SHALL follow reset release until a new grant.
REQ-022 After release, the first video fetch SHALL occur in slots 0-1 of the first counter pass.

Structure
REQ-023 Slot numbers (VID0=0, VID1=1, CPU0=2, CPU1=3) and the FSM state encoding SHALL live in the shared neo_pkg package.
REQ-024 The slot counter with its PIXSYNC resync SHALL be a sub-module named neo_palslot; the arbiter FSM, latches and strobes SHALL stay in neo_palarb.

Verification
REQ-025 Write during active display: nPAL=0 at SLOT=3, RW=0, addr 0x123, data 0xBEEF, both lanes -> nPALWEL/U low one cycle in slot 3 of next pass, PAL_ADDR 0x0123, nPALDTACK low 1 cycle later.
REQ-026 Read: preload 0x1ABC=0x7FFF, PALBNK=1, CPU_ADDR=0xABC read -> CPU_RDATA=0x7FFF at ACK, VID_COLOR unaffected.
REQ-027 Byte write nUDS=1, nLDS=0 -> only nPALWEL strobes; upper byte of RAM unchanged.
REQ-028 Blanking: nBNKB=0, request before slot 0 -> grant at slot 0, video fetch skipped, VID_COLOR holds prior value.
REQ-029 Abort: nPAL rises during ACCESS1 -> access completes, nPALDTACK stays 1, FSM returns to IDLE.
REQ-030 Reset mid-ACCESS2 write -> strobes high immediately, all outputs at reset values, no strobe after release.
